// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array front end (control unit and
// operand buffer): operand width, byte addresses, operand select codes.
package tpu_pkg;

  localparam int DW = 8;

  // Byte addresses within one operand set (row-major A, then row-major B)
  localparam logic [2:0] ADDR_W0 = 3'd0;
  localparam logic [2:0] ADDR_W1 = 3'd1;
  localparam logic [2:0] ADDR_W2 = 3'd2;
  localparam logic [2:0] ADDR_W3 = 3'd3;
  localparam logic [2:0] ADDR_X0 = 3'd4;
  localparam logic [2:0] ADDR_X1 = 3'd5;
  localparam logic [2:0] ADDR_X2 = 3'd6;
  localparam logic [2:0] ADDR_X3 = 3'd7;

  // Operand select codes; 2'd3 is unused and also yields zero
  localparam logic [1:0] SEL_0    = 2'd0;
  localparam logic [1:0] SEL_1    = 2'd1;
  localparam logic [1:0] SEL_ZERO = 2'd2;

endpackage

// File: rtl/operand_mux.sv
// Combinational operand selection from the active bank.
// Ports: bank (8 packed bytes, index = byte address), tr (transpose of B),
//        a0_sel..b1_sel (select codes), a0..b1 (signed operands).
module operand_mux
  import tpu_pkg::*;
#(
  parameter int DW = tpu_pkg::DW
) (
  input  logic [7:0][DW-1:0] bank,
  input  logic               tr,
  input  logic [1:0]         a0_sel,
  input  logic [1:0]         a1_sel,
  input  logic [1:0]         b0_sel,
  input  logic [1:0]         b1_sel,
  output logic signed [DW-1:0] a0,
  output logic signed [DW-1:0] a1,
  output logic signed [DW-1:0] b0,
  output logic signed [DW-1:0] b1
);

  always_comb begin
    a0 = '0;
    a1 = '0;
    b0 = '0;
    b1 = '0;
    case (a0_sel)
      SEL_0:   a0 = bank[ADDR_W0];
      SEL_1:   a0 = bank[ADDR_W1];
      default: a0 = '0;
    endcase
    case (a1_sel)
      SEL_0:   a1 = bank[ADDR_W2];
      SEL_1:   a1 = bank[ADDR_W3];
      default: a1 = '0;
    endcase
    // Transpose only swaps the off-diagonal input bytes x1/x2
    case (b0_sel)
      SEL_0:   b0 = bank[ADDR_X0];
      SEL_1:   b0 = tr ? bank[ADDR_X1] : bank[ADDR_X2];
      default: b0 = '0;
    endcase
    case (b1_sel)
      SEL_0:   b1 = tr ? bank[ADDR_X2] : bank[ADDR_X1];
      SEL_1:   b1 = bank[ADDR_X3];
      default: b1 = '0;
    endcase
  end

endmodule

// File: rtl/operand_buffer.sv
// Double-buffered operand store feeding the 2x2 systolic array.
// Host bytes land in a shadow bank; a complete set swaps into the active
// bank on the address-7 write. Operands are registered, zero until the
// first successful swap.
// Ports: clk, rst (sync, active-high); load_en/mem_addr/host_indata (host
//        byte write); transpose (latched at swap); a0_sel..b1_sel (select
//        codes); a0..b1 (registered signed operands); bank_valid; load_err
//        (sticky incomplete-set flag).
module operand_buffer
  import tpu_pkg::*;
#(
  parameter int DW = tpu_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [2:0]           mem_addr,
  input  logic [DW-1:0]        host_indata,
  input  logic                 transpose,
  input  logic [1:0]           a0_sel,
  input  logic [1:0]           a1_sel,
  input  logic [1:0]           b0_sel,
  input  logic [1:0]           b1_sel,
  output logic signed [DW-1:0] a0,
  output logic signed [DW-1:0] a1,
  output logic signed [DW-1:0] b0,
  output logic signed [DW-1:0] b1,
  output logic                 bank_valid,
  output logic                 load_err
);

  logic [7:0][DW-1:0] shadow, active;
  logic [7:0]         written;
  logic               active_tr;
  logic               swap_req, set_full;
  logic signed [DW-1:0] m_a0, m_a1, m_b0, m_b1;

  assign swap_req = load_en && (mem_addr == ADDR_X3);
  assign set_full = &written[6:0];

  operand_mux #(.DW(DW)) u_mux (
    .bank   (active),
    .tr     (active_tr),
    .a0_sel (a0_sel),
    .a1_sel (a1_sel),
    .b0_sel (b0_sel),
    .b1_sel (b1_sel),
    .a0     (m_a0),
    .a1     (m_a1),
    .b0     (m_b0),
    .b1     (m_b1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      active     <= '0;
      written    <= '0;
      active_tr  <= 1'b0;
      bank_valid <= 1'b0;
      load_err   <= 1'b0;
      a0         <= '0;
      a1         <= '0;
      b0         <= '0;
      b1         <= '0;
    end else begin
      if (load_en) begin
        shadow[mem_addr]  <= host_indata;
        written[mem_addr] <= 1'b1;
      end
      // Either outcome of an address-7 write starts the next set clean;
      // this overrides the mask set above.
      if (swap_req) begin
        written <= '0;
        if (set_full) begin
          active          <= shadow;
          active[ADDR_X3] <= host_indata;   // byte 7 arrives this cycle
          active_tr       <= transpose;
          bank_valid      <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end
      // Uses pre-edge active bank, so the swap edge still shows the old set
      a0 <= bank_valid ? m_a0 : '0;
      a1 <= bank_valid ? m_a1 : '0;
      b0 <= bank_valid ? m_b0 : '0;
      b1 <= bank_valid ? m_b1 : '0;
    end
  end

endmodule

// File: tb/tb_operand_buffer.sv
module tb_operand_buffer;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic [2:0]        mem_addr;
  logic [7:0]        host_indata;
  logic              transpose;
  logic [1:0]        a0_sel, a1_sel, b0_sel, b1_sel;
  logic signed [7:0] a0, a1, b0, b1;
  logic              bank_valid, load_err;

  operand_buffer #(.DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .mem_addr    (mem_addr),
    .host_indata (host_indata),
    .transpose   (transpose),
    .a0_sel      (a0_sel),
    .a1_sel      (a1_sel),
    .b0_sel      (b0_sel),
    .b1_sel      (b1_sel),
    .a0          (a0),
    .a1          (a1),
    .b0          (b0),
    .b1          (b1),
    .bank_valid  (bank_valid),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: two byte arrays, a write mask, flags
  logic [7:0] sh [8];
  logic [7:0] act[8];
  bit         wr [8];
  bit         m_tr, m_valid, m_err;
  logic [7:0] e_a0, e_a1, e_b0, e_b1;

  // Operand for a 2x2 product: A row r picks column sel, B column c picks row sel
  function automatic logic [7:0] ref_op(input int which, input logic [1:0] sel);
    int r, c;
    if (!m_valid || sel > 2'd1) return 8'h00;
    case (which)
      0: return act[0 + sel];                  // A[0][sel]
      1: return act[2 + sel];                  // A[1][sel]
      2: begin r = sel; c = 0; end             // B[sel][0]
      default: begin r = sel; c = 1; end       // B[sel][1]
    endcase
    return m_tr ? act[4 + 2*c + r] : act[4 + 2*r + c];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin sh[i] = 0; act[i] = 0; wr[i] = 0; end
    m_tr = 0; m_valid = 0; m_err = 0;
  endtask

  // One clock: predict, advance the model, then compare at the falling edge
  task automatic tick();
    bit full;
    if (rst) begin
      e_a0 = 0; e_a1 = 0; e_b0 = 0; e_b1 = 0;
      model_reset();
    end else begin
      e_a0 = ref_op(0, a0_sel);
      e_a1 = ref_op(1, a1_sel);
      e_b0 = ref_op(2, b0_sel);
      e_b1 = ref_op(3, b1_sel);
      if (load_en) begin
        sh[mem_addr] = host_indata;
        if (mem_addr == 3'd7) begin
          full = 1;
          for (int i = 0; i < 7; i++) if (!wr[i]) full = 0;
          if (full) begin
            for (int i = 0; i < 8; i++) act[i] = sh[i];
            m_tr = transpose; m_valid = 1;
          end else m_err = 1;
          for (int i = 0; i < 8; i++) wr[i] = 0;
        end else wr[mem_addr] = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("a0", a0, e_a0);
    chk("a1", a1, e_a1);
    chk("b0", b0, e_b0);
    chk("b1", b1, e_b1);
    chk("bank_valid", {7'd0, bank_valid}, {7'd0, m_valid});
    chk("load_err", {7'd0, load_err}, {7'd0, m_err});
  endtask

  task automatic set_sel(input logic [1:0] s);
    a0_sel = s; a1_sel = s; b0_sel = s; b1_sel = s;
  endtask

  task automatic put(input logic [2:0] addr, input logic [7:0] d);
    load_en = 1; mem_addr = addr; host_indata = d;
    tick();
    load_en = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    for (int i = 0; i < n; i++) tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; load_en = 0; mem_addr = 0; host_indata = 0; transpose = 0;
    set_sel(2'd0);
    model_reset();
    @(negedge clk);

    // Reset then idle
    do_reset(2);
    tick();
    chk("rst_a0", a0, 8'd0);
    chk("rst_valid", {7'd0, bank_valid}, 8'd0);
    chk("rst_err", {7'd0, load_err}, 8'd0);

    // Full load, no transpose
    for (int i = 0; i < 8; i++) put(3'(i), 8'(i + 1));
    chk("load_valid", {7'd0, bank_valid}, 8'd1);
    tick();
    chk("s0_a0", a0, 8'd1); chk("s0_a1", a1, 8'd3);
    chk("s0_b0", b0, 8'd5); chk("s0_b1", b1, 8'd6);
    set_sel(2'd1); tick();
    chk("s1_a0", a0, 8'd2); chk("s1_a1", a1, 8'd4);
    chk("s1_b0", b0, 8'd7); chk("s1_b1", b1, 8'd8);
    set_sel(2'd2); tick();
    chk("szero_b1", b1, 8'd0);

    // Transpose
    transpose = 1;
    for (int i = 0; i < 8; i++) put(3'(i), 8'(i + 1));
    set_sel(2'd1); tick();
    chk("tr_b0", b0, 8'd6);
    set_sel(2'd0); tick();
    chk("tr_b1", b1, 8'd7);
    transpose = 0; tick(); tick();
    chk("tr_held_b1", b1, 8'd7);

    // Double buffering
    for (int i = 0; i < 7; i++) put(3'(i), 8'hFF);
    chk("db_a0_old", a0, 8'd1);
    put(3'd7, 8'h80);
    tick();
    chk("db_a0_new", a0, 8'hFF);
    set_sel(2'd1); tick();
    chk("db_b1_new", b1, 8'h80);
    set_sel(2'd0);

    // Incomplete set
    do_reset(1);
    for (int i = 0; i < 6; i++) put(3'(i), 8'(8'h10 + i));
    put(3'd7, 8'h17);
    tick();
    chk("inc_err", {7'd0, load_err}, 8'd1);
    chk("inc_valid", {7'd0, bank_valid}, 8'd0);
    chk("inc_a0", a0, 8'd0);
    for (int i = 0; i < 8; i++) put(3'(i), 8'(8'h20 + i));
    tick();
    chk("inc2_valid", {7'd0, bank_valid}, 8'd1);
    chk("inc2_err", {7'd0, load_err}, 8'd1);
    chk("inc2_b0", b0, 8'h24);

    // Mid-load reset
    for (int i = 0; i < 5; i++) put(3'(i), 8'(8'h30 + i));
    do_reset(1);
    for (int i = 5; i < 8; i++) put(3'(i), 8'(8'h30 + i));
    tick();
    chk("mid_err", {7'd0, load_err}, 8'd1);
    chk("mid_valid", {7'd0, bank_valid}, 8'd0);
    chk("mid_a1", a1, 8'd0);

    // Randomized traffic, mostly sequential addresses with occasional jumps
    begin
      logic [2:0] nxt;
      nxt = 0;
      for (int k = 0; k < 1500; k++) begin
        rst         = ($urandom_range(0, 199) == 0);
        load_en     = ($urandom_range(0, 3) != 0);
        mem_addr    = ($urandom_range(0, 9) == 0) ? 3'($urandom) : nxt;
        host_indata = 8'($urandom);
        transpose   = 1'($urandom);
        a0_sel = 2'($urandom); a1_sel = 2'($urandom);
        b0_sel = 2'($urandom); b1_sel = 2'($urandom);
        if (load_en) nxt = mem_addr + 3'd1;
        tick();
      end
      rst = 0; load_en = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
